// File: rtl/m_store_buffer.sv
// m_store_buffer: posted-write FIFO between the M-stage byte-enable generator and data memory.
// The M stage retires stores into this buffer, and the buffer drains them in order
// over a req/ack handshake. The buffer also reports pending same-word stores
// (ld_hit) so that the hazard unit can stall dependent loads.
//
// Optional feature macro: STORE_COALESCE_EN. When it is defined, a push to the same
// word as the newest, non-head entry merges into that entry.
//
// Ports:
//   clk, reset          clock; asynchronous active-low reset
//   in_valid/addr/byte_en/wdata, in_ready   store input (byte_en == 0 is dropped)
//   ld_check, ld_addr, ld_hit               load hazard lookup (word compare)
//   mem_req/addr/byte_en/wdata, mem_ack     drain handshake for the head entry
//   empty, count                            occupancy

// One buffer slot. Storage is not reset. A slot is either fully written on
// allocation or lane-merged when a store coalesces into it.
module m_store_buffer_entry (
  input  logic        clk,
  input  logic        wr_en,
  input  logic        merge_en,
  input  logic [29:0] wr_word,
  input  logic [3:0]  wr_be,
  input  logic [31:0] wr_data,
  input  logic [29:0] ld_word,
  output logic [29:0] ent_word,
  output logic [3:0]  ent_be,
  output logic [31:0] ent_data,
  output logic        ld_match
);
  always_ff @(posedge clk) begin
    if (wr_en) begin
      ent_word <= wr_word;
      ent_be   <= wr_be;
      ent_data <= wr_data;
    end else if (merge_en) begin
      ent_be <= ent_be | wr_be;
      for (int b = 0; b < 4; b++)
        if (wr_be[b]) ent_data[8*b +: 8] <= wr_data[8*b +: 8];
    end
  end

  assign ld_match = (ent_word == ld_word);
endmodule

module m_store_buffer #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [31:0]      in_addr,
  input  logic [3:0]       in_byte_en,
  input  logic [31:0]      in_wdata,
  output logic             in_ready,
  input  logic             ld_check,
  input  logic [31:0]      ld_addr,
  output logic             ld_hit,
  output logic             mem_req,
  output logic [31:0]      mem_addr,
  output logic [3:0]       mem_byte_en,
  output logic [31:0]      mem_wdata,
  input  logic             mem_ack,
  output logic             empty,
  output logic [CNT_W-1:0] count
);
  localparam int PTR_W = $clog2(DEPTH);

  logic [PTR_W-1:0] head, tail, newest;
  logic [CNT_W-1:0] cnt;
  logic             full, coalesce, push, alloc, merge, pop;

  logic [DEPTH-1:0][29:0] e_word;
  logic [DEPTH-1:0][3:0]  e_be;
  logic [DEPTH-1:0][31:0] e_data;
  logic [DEPTH-1:0]       e_vld, e_match, e_wr, e_merge;

  // Byte-offset bits are meaningless for word-granular tracking.
  logic unused_addr_lsbs;
  assign unused_addr_lsbs = ^{in_addr[1:0], ld_addr[1:0]};

  assign newest = tail - PTR_W'(1);
  assign full   = (cnt == CNT_W'(DEPTH));
  assign empty  = (cnt == '0);

`ifdef STORE_COALESCE_EN
  // The count >= 2 condition keeps a merge away from the head. The head may be
  // in the middle of being presented to memory, so it must not change.
  assign coalesce = in_valid && (|in_byte_en) && (cnt >= CNT_W'(2)) &&
                    (e_word[newest] == in_addr[31:2]);
  assign in_ready = !full || coalesce;
`else
  assign coalesce = 1'b0;
  assign in_ready = !full;
`endif

  // in_ready depends only on current state, so a same-cycle pop never frees the slot.
  assign push  = in_valid && (|in_byte_en) && in_ready;
  assign alloc = push && !coalesce;
  assign merge = push && coalesce;
  assign pop   = mem_req && mem_ack;

  genvar i;
  generate
    for (i = 0; i < DEPTH; i++) begin : g_ent
      logic [PTR_W-1:0] off;
      // A slot is valid when its distance from head is below the occupancy count.
      assign off        = PTR_W'(i) - head;
      assign e_vld[i]   = (CNT_W'(off) < cnt);
      assign e_wr[i]    = alloc && (tail == PTR_W'(i));
      assign e_merge[i] = merge && (newest == PTR_W'(i));

      m_store_buffer_entry u_ent (
        .clk      (clk),
        .wr_en    (e_wr[i]),
        .merge_en (e_merge[i]),
        .wr_word  (in_addr[31:2]),
        .wr_be    (in_byte_en),
        .wr_data  (in_wdata),
        .ld_word  (ld_addr[31:2]),
        .ent_word (e_word[i]),
        .ent_be   (e_be[i]),
        .ent_data (e_data[i]),
        .ld_match (e_match[i])
      );
    end
  endgenerate

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head <= '0;
      tail <= '0;
      cnt  <= '0;
    end else begin
      if (alloc) tail <= tail + PTR_W'(1);
      if (pop)   head <= head + PTR_W'(1);
      case ({alloc, pop})
        2'b10:   cnt <= cnt + CNT_W'(1);
        2'b01:   cnt <= cnt - CNT_W'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  // The head lookup covers the entry that is being acked in this same cycle.
  // The same-cycle push is not yet valid, so the lookup does not see it.
  assign ld_hit      = ld_check && |(e_vld & e_match);
  assign mem_req     = !empty;
  assign mem_addr    = empty ? 32'h0 : {e_word[head], 2'b00};
  assign mem_byte_en = empty ? 4'h0  : e_be[head];
  assign mem_wdata   = empty ? 32'h0 : e_data[head];
  assign count       = cnt;
endmodule

// File: tb/tb_m_store_buffer.sv
module tb_m_store_buffer;
  localparam int DEPTH = 4;
  localparam int CNT_W = 3;

  logic             clk = 1'b0;
  logic             reset;
  logic             in_valid;
  logic [31:0]      in_addr;
  logic [3:0]       in_byte_en;
  logic [31:0]      in_wdata;
  logic             in_ready;
  logic             ld_check;
  logic [31:0]      ld_addr;
  logic             ld_hit;
  logic             mem_req;
  logic [31:0]      mem_addr;
  logic [3:0]       mem_byte_en;
  logic [31:0]      mem_wdata;
  logic             mem_ack;
  logic             empty;
  logic [CNT_W-1:0] count;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] data;
  } ent_t;
  ent_t q[$];

  m_store_buffer #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_addr(in_addr), .in_byte_en(in_byte_en),
    .in_wdata(in_wdata), .in_ready(in_ready),
    .ld_check(ld_check), .ld_addr(ld_addr), .ld_hit(ld_hit),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_byte_en(mem_byte_en),
    .mem_wdata(mem_wdata), .mem_ack(mem_ack),
    .empty(empty), .count(count)
  );

  always #5 clk = ~clk;

  // Scoreboard. Inputs change only at posedge+1, so they are stable at the negedge.
  // The handshake that is seen here completes at the following posedge.
  always @(negedge clk) begin
    int   sz;
    logic mrg, rdy;
    ent_t e;
    if (!reset) q.delete();
    else begin
      sz  = q.size();
      mrg = 1'b0;
`ifdef STORE_COALESCE_EN
      if (sz >= 2 && in_valid && in_byte_en != 4'h0 && q[sz-1].addr[31:2] == in_addr[31:2])
        mrg = 1'b1;
`endif
      rdy = (sz < DEPTH) || mrg;
      total++;
      if (in_ready !== rdy) begin
        bad++; $display("FAIL sb_in_ready: got %b want %b", in_ready, rdy);
      end
      total++;
      if (count !== sz[CNT_W-1:0]) begin
        bad++; $display("FAIL sb_count: got %0d want %0d", count, sz);
      end
      total++;
      if (mem_req !== (sz != 0) || empty !== (sz == 0)) begin
        bad++; $display("FAIL sb_req_empty: got req=%b empty=%b want entries=%0d", mem_req, empty, sz);
      end
      if (in_valid && in_byte_en != 4'h0 && rdy && mrg) begin
        e = q[sz-1];
        e.be = e.be | in_byte_en;
        for (int b = 0; b < 4; b++)
          if (in_byte_en[b]) e.data[8*b +: 8] = in_wdata[8*b +: 8];
        q[sz-1] = e;
      end
      if (sz > 0 && mem_ack) begin
        e = q.pop_front();
        total++;
        if (mem_addr !== e.addr || mem_byte_en !== e.be || mem_wdata !== e.data) begin
          bad++;
          $display("FAIL sb_drain: got %h/%b/%h want %h/%b/%h",
                   mem_addr, mem_byte_en, mem_wdata, e.addr, e.be, e.data);
        end
      end
      if (in_valid && in_byte_en != 4'h0 && rdy && !mrg) begin
        e.addr = {in_addr[31:2], 2'b00};
        e.be   = in_byte_en;
        e.data = in_wdata;
        q.push_back(e);
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] a, input logic [3:0] be, input logic [31:0] d);
    in_valid = 1'b1; in_addr = a; in_byte_en = be; in_wdata = d;
    cyc();
    in_valid = 1'b0;
  endtask

  task automatic drain();
    mem_ack = 1'b1;
    for (int k = 0; k < 10 && count != 0; k++) cyc();
    mem_ack = 1'b0;
    #1;
    total++;
    if (empty !== 1'b1) begin
      bad++; $display("FAIL drain_timeout: got count=%0d want 0", count);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0; in_valid = 1'b1; in_addr = 32'h100; in_byte_en = 4'hF;
    in_wdata = 32'h1; ld_check = 1'b1; ld_addr = 32'h100; mem_ack = 1'b0;
    cyc(); cyc();
    total++;
    if (count !== 3'd0 || mem_req !== 1'b0 || in_ready !== 1'b1 || empty !== 1'b1 || ld_hit !== 1'b0) begin
      bad++; $display("FAIL reset_state: got cnt=%0d req=%b rdy=%b empty=%b hit=%b want 0/0/1/1/0",
                      count, mem_req, in_ready, empty, ld_hit);
    end
    total++;
    if (mem_addr !== 32'h0 || mem_byte_en !== 4'h0 || mem_wdata !== 32'h0) begin
      bad++; $display("FAIL reset_mem_zero: got %h/%b/%h want zeros", mem_addr, mem_byte_en, mem_wdata);
    end
    reset = 1'b1; in_valid = 1'b0; ld_check = 1'b0;
    cyc();
    total++;
    if (count !== 3'd0) begin
      bad++; $display("FAIL reset_release: got count=%0d want 0", count);
    end
    // Zero byte enables must be dropped.
    in_valid = 1'b1; in_byte_en = 4'h0;
    cyc();
    in_valid = 1'b0;
    total++;
    if (count !== 3'd0) begin
      bad++; $display("FAIL zero_be_drop: got count=%0d want 0", count);
    end
  endtask

  task automatic test_single();
    push(32'h10, 4'hF, 32'hDEADBEEF);
    for (int k = 0; k < 4; k++) begin
      #1;
      total++;
      if (mem_req !== 1'b1 || mem_addr !== 32'h10 || mem_byte_en !== 4'hF ||
          mem_wdata !== 32'hDEADBEEF || count !== 3'd1) begin
        bad++; $display("FAIL single_hold%0d: got req=%b %h/%b/%h cnt=%0d want 1 00000010/1111/deadbeef cnt=1",
                        k, mem_req, mem_addr, mem_byte_en, mem_wdata, count);
      end
      if (k < 3) cyc();
    end
    mem_ack = 1'b1;
    cyc();
    mem_ack = 1'b0;
    #1;
    total++;
    if (count !== 3'd0 || mem_req !== 1'b0 || mem_addr !== 32'h0) begin
      bad++; $display("FAIL single_ack: got cnt=%0d req=%b addr=%h want 0/0/0", count, mem_req, mem_addr);
    end
  endtask

  task automatic test_full();
    for (int k = 0; k < 4; k++) push(32'h4 * k, 4'hF, 32'hA000 + k);
    #1;
    total++;
    if (in_ready !== 1'b0 || count !== 3'd4) begin
      bad++; $display("FAIL full_ready: got rdy=%b cnt=%0d want 0/4", in_ready, count);
    end
    push(32'h30, 4'hF, 32'h5);
    #1;
    total++;
    if (count !== 3'd4) begin
      bad++; $display("FAIL full_reject: got count=%0d want 4", count);
    end
    mem_ack = 1'b1;
    push(32'h34, 4'hF, 32'h6);
    mem_ack = 1'b0;
    #1;
    total++;
    if (count !== 3'd3 || in_ready !== 1'b1) begin
      bad++; $display("FAIL full_push_ack: got cnt=%0d rdy=%b want 3/1", count, in_ready);
    end
    drain();
  endtask

  task automatic test_ld_hit();
    push(32'h20, 4'hF, 32'h12345678);
    ld_check = 1'b1; ld_addr = 32'h23;
    #1;
    total++;
    if (ld_hit !== 1'b1) begin bad++; $display("FAIL ld_same_word: got %b want 1", ld_hit); end
    ld_addr = 32'h24;
    #1;
    total++;
    if (ld_hit !== 1'b0) begin bad++; $display("FAIL ld_next_word: got %b want 0", ld_hit); end
    ld_check = 1'b0; ld_addr = 32'h20;
    #1;
    total++;
    if (ld_hit !== 1'b0) begin bad++; $display("FAIL ld_no_check: got %b want 0", ld_hit); end
    cyc();
    ld_check = 1'b1; ld_addr = 32'h50;
    in_valid = 1'b1; in_addr = 32'h50; in_byte_en = 4'hF; in_wdata = 32'h55;
    #1;
    total++;
    if (ld_hit !== 1'b0) begin bad++; $display("FAIL ld_same_cycle_push: got %b want 0", ld_hit); end
    cyc();
    in_valid = 1'b0;
    #1;
    total++;
    if (ld_hit !== 1'b1) begin bad++; $display("FAIL ld_after_push: got %b want 1", ld_hit); end
    mem_ack = 1'b1;
    cyc(); cyc();
    mem_ack = 1'b0; ld_addr = 32'h20;
    #1;
    total++;
    if (ld_hit !== 1'b0 || empty !== 1'b1) begin
      bad++; $display("FAIL ld_after_drain: got hit=%b empty=%b want 0/1", ld_hit, empty);
    end
    ld_check = 1'b0;
  endtask

  task automatic test_wrap();
    mem_ack = 1'b1;
    for (int k = 0; k < 6; k++) begin
      in_valid = 1'b1; in_addr = 32'h100 + 32'h4 * k;
      in_byte_en = 4'($urandom_range(1, 15)); in_wdata = $urandom;
      cyc();
    end
    in_valid = 1'b0;
    #1;
    total++;
    if (count !== 3'd1) begin bad++; $display("FAIL wrap_steady: got count=%0d want 1", count); end
    cyc();
    mem_ack = 1'b0;
    #1;
    total++;
    if (count !== 3'd0) begin bad++; $display("FAIL wrap_end: got count=%0d want 0", count); end
  endtask

  task automatic test_coalesce();
    push(32'h0,  4'hF, 32'h11111111);
    push(32'h40, 4'h1, 32'h000000AA);
    push(32'h41, 4'h2, 32'h0000BB00);
    #1;
    total++;
`ifdef STORE_COALESCE_EN
    if (count !== 3'd2) begin bad++; $display("FAIL coal_count: got %0d want 2", count); end
`else
    if (count !== 3'd3) begin bad++; $display("FAIL coal_count: got %0d want 3", count); end
`endif
    mem_ack = 1'b1;
    cyc();
    mem_ack = 1'b0;
    #1;
    total++;
`ifdef STORE_COALESCE_EN
    if (mem_byte_en !== 4'b0011 || mem_wdata[15:0] !== 16'hBBAA) begin
      bad++; $display("FAIL coal_merge: got %b/%h want 0011/bbaa", mem_byte_en, mem_wdata[15:0]);
    end
`else
    if (mem_byte_en !== 4'b0001 || mem_wdata[15:0] !== 16'h00AA) begin
      bad++; $display("FAIL coal_merge: got %b/%h want 0001/00aa", mem_byte_en, mem_wdata[15:0]);
    end
`endif
    drain();
    // A same-word push onto a single (head) entry always allocates.
    push(32'h80, 4'hF, 32'h1);
    push(32'h80, 4'h1, 32'h2);
    #1;
    total++;
    if (count !== 3'd2) begin bad++; $display("FAIL coal_head_guard: got %0d want 2", count); end
    push(32'h84, 4'hF, 32'h3);
    push(32'h88, 4'hF, 32'h4);
    in_valid = 1'b1; in_addr = 32'h8A; in_byte_en = 4'b0100; in_wdata = 32'h00CC0000;
    #1;
    total++;
`ifdef STORE_COALESCE_EN
    if (in_ready !== 1'b1) begin bad++; $display("FAIL coal_full_ready: got %b want 1", in_ready); end
`else
    if (in_ready !== 1'b0) begin bad++; $display("FAIL coal_full_ready: got %b want 0", in_ready); end
`endif
    cyc();
    in_valid = 1'b0;
    #1;
    total++;
    if (count !== 3'd4) begin bad++; $display("FAIL coal_full_count: got %0d want 4", count); end
    drain();
  endtask

  task automatic test_reset_mid_drain();
    push(32'h200, 4'hF, 32'h7);
    push(32'h204, 4'hF, 32'h8);
    reset = 1'b0; mem_ack = 1'b1;
    #1;
    total++;
    if (count !== 3'd0 || mem_req !== 1'b0) begin
      bad++; $display("FAIL mid_reset: got cnt=%0d req=%b want 0/0", count, mem_req);
    end
    cyc();
    reset = 1'b1;
    cyc();
    mem_ack = 1'b0;
    #1;
    total++;
    if (count !== 3'd0 || empty !== 1'b1) begin
      bad++; $display("FAIL mid_reset_ack_idle: got cnt=%0d empty=%b want 0/1", count, empty);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_full();
    test_ld_hit();
    test_wrap();
    test_coalesce();
    test_reset_mid_drain();
    cyc();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
